// File: rtl/pkt_assembler_mc_if.sv
// Event-channel and packet-link handshake bundle for pkt_assembler_mc.
// The assembler takes the slave side; the event sources / packet sink take the master side.
interface pkt_assembler_mc_if #(
    parameter int NUM_CH = 4
);
    logic [31:0]       evt_data_in [NUM_CH];
    logic [31:0]       evt_pld_in  [NUM_CH];
    logic [NUM_CH-1:0] evt_vld_in;
    logic [NUM_CH-1:0] evt_rdy_out;
    logic [71:0]       pkt_data_out;
    logic              pkt_vld_out;
    logic              pkt_rdy_in;

    modport slave (
        input  evt_data_in,
        input  evt_pld_in,
        input  evt_vld_in,
        output evt_rdy_out,
        output pkt_data_out,
        output pkt_vld_out,
        input  pkt_rdy_in
    );

    modport master (
        output evt_data_in,
        output evt_pld_in,
        output evt_vld_in,
        input  evt_rdy_out,
        input  pkt_data_out,
        input  pkt_vld_out,
        output pkt_rdy_in
    );
endinterface

// File: rtl/pkt_assembler_mc.sv
// Multi-channel SpiNNaker multicast packet assembler: round-robin event arbitration,
// mask/shift key mapping with odd-parity header, and an output packet queue.
module pkt_assembler_mc #(
    parameter int NUM_CH     = 4,
    parameter int NUM_FIELDS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 mp_key_in    [NUM_CH],
    input  logic [31:0]                 field_msk_in [NUM_CH][NUM_FIELDS],
    input  logic [5:0]                  field_sft_in [NUM_CH][NUM_FIELDS],
    input  logic [NUM_CH-1:0]           pld_en_in,
    pkt_assembler_mc_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_lvl_out,
    output logic [31:0]                 pkt_cnt_out
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [CH_W-1:0] rr_q, rr_d, gnt, cand;
    logic            gnt_vld, full, push, pop;
    logic [31:0]     key, field, pld;
    logic [4:0]      lsh;
    logic [7:0]      hdr;
    logic [71:0]     pkt;
    logic [71:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [31:0]     cnt_q, cnt_d;

    // First valid channel searching upward from the round-robin pointer.
    always_comb begin : arbiter
        gnt     = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((32'(rr_q) + i) % NUM_CH);
            if (!gnt_vld && bus.evt_vld_in[cand]) begin
                gnt     = cand;
                gnt_vld = 1'b1;
            end
        end
    end

    assign full = (lvl_q == DEPTH_L);
    assign push = gnt_vld && !full && reset_n;
    assign pop  = (lvl_q != '0) && bus.pkt_rdy_in;

    always_comb begin : ready_gen
        bus.evt_rdy_out = '0;
        if (push) begin
            bus.evt_rdy_out[gnt] = 1'b1;
        end
    end

    // Shift code bit 5 selects left shift by the two's complement of the low five bits.
    always_comb begin : mapper
        key   = mp_key_in[gnt];
        field = '0;
        lsh   = '0;
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
            field = bus.evt_data_in[gnt] & field_msk_in[gnt][f];
            lsh   = ~field_sft_in[gnt][f][4:0] + 5'd1;
            if (field_sft_in[gnt][f][5]) begin
                key = key | (field << lsh);
            end else begin
                key = key | (field >> field_sft_in[gnt][f][4:0]);
            end
        end
        pld    = pld_en_in[gnt] ? bus.evt_pld_in[gnt] : '0;
        hdr    = {6'b0, pld_en_in[gnt], 1'b0};
        hdr[0] = ~^{pld, key, hdr[7:1]};
        pkt    = {pld, key, hdr};
    end

    always_comb begin : next_state
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        cnt_d    = cnt_q;
        if (push) begin
            rr_d     = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q + 32'd1;
        end
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin : state_regs
        if (!reset_n) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            cnt_q    <= cnt_d;
        end
    end

    // Queue storage needs no reset; occupancy alone qualifies the head.
    always_ff @(posedge clk) begin : queue_mem
        if (push) begin
            mem_q[wr_ptr_q] <= pkt;
        end
    end

    assign bus.pkt_data_out = mem_q[rd_ptr_q];
    assign bus.pkt_vld_out  = (lvl_q != '0);
    assign fifo_lvl_out     = lvl_q;
    assign pkt_cnt_out      = cnt_q;
endmodule

// File: tb/tb_pkt_assembler_mc.sv
// Scoreboard bench for pkt_assembler_mc: directed events push expected packets,
// an independent monitor pops and compares on every output transfer.
module tb_pkt_assembler_mc;
    localparam int NCH = 4;
    localparam int NF  = 4;
    localparam int FD  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       mp_key [NCH];
    logic [31:0]       msk    [NCH][NF];
    logic [5:0]        sft    [NCH][NF];
    logic [NCH-1:0]    pld_en;
    logic [2:0]        lvl;
    logic [31:0]       cnt;

    int                tests = 0;
    int                fails = 0;
    logic [71:0]       sb [$];
    int                acc_seq [$];
    logic [71:0]       cur_exp [NCH];
    logic [NCH-1:0]    accepted;
    logic [31:0]       exp_cnt;
    logic              stall_prev = 1'b0;
    logic [71:0]       data_prev;
    logic [7:0]        htab [10] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00,
                                     8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
    int                rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    time               t0;

    always #5 clk = ~clk;

    pkt_assembler_mc_if #(.NUM_CH(NCH)) bus ();

    pkt_assembler_mc #(
        .NUM_CH    (NCH),
        .NUM_FIELDS(NF),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mp_key_in   (mp_key),
        .field_msk_in(msk),
        .field_sft_in(sft),
        .pld_en_in   (pld_en),
        .bus         (bus),
        .fifo_lvl_out(lvl),
        .pkt_cnt_out (cnt)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (bus.pkt_vld_out) begin
            if (stall_prev) chk("hold_stable", bus.pkt_data_out, data_prev);
            if (bus.pkt_rdy_in) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pkt: got %h, required no packet", bus.pkt_data_out);
                end else begin
                    chk("pkt_data", bus.pkt_data_out, sb.pop_front());
                end
                chk("pkt_cnt_pre", 72'(cnt), 72'(exp_cnt));
                exp_cnt    = exp_cnt + 32'd1;
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                data_prev  = bus.pkt_data_out;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Called at negedge+1; returns at the following negedge+1.
    task automatic cycle();
        #2;
        chk("rdy_onehot", 72'($countones(bus.evt_rdy_out) <= 1), 72'd1);
        for (int c = 0; c < NCH; c++) begin
            if (bus.evt_rdy_out[c]) begin
                acc_seq.push_back(c);
                sb.push_back(cur_exp[c]);
                accepted[c] = 1'b1;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [31:0] d, input logic [31:0] p,
                        input logic [71:0] e);
        bus.evt_data_in[c] = d;
        bus.evt_pld_in[c]  = p;
        bus.evt_vld_in[c]  = 1'b1;
        cur_exp[c]         = e;
        accepted[c]        = 1'b0;
        for (int n = 0; n < 40 && !accepted[c]; n++) cycle();
        if (!accepted[c]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: ch%0d not accepted, required accept within 40 cycles", c);
        end
        bus.evt_vld_in[c] = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && (sb.size() != 0 || bus.pkt_vld_out); n++) begin
            @(negedge clk);
            #1;
        end
        chk({name, "_drained"}, 72'(sb.size()), 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b1;
        bus.pkt_rdy_in  = 1'b0;
        bus.evt_vld_in  = '0;
        pld_en          = '0;
        accepted        = '0;
        exp_cnt         = '0;
        for (int c = 0; c < NCH; c++) begin
            bus.evt_data_in[c] = '0;
            bus.evt_pld_in[c]  = '0;
            cur_exp[c]         = '0;
            for (int f = 0; f < NF; f++) begin
                msk[c][f] = '0;
                sft[c][f] = '0;
            end
            msk[c][0] = 32'h0000_00FF;
        end
        mp_key[0] = 32'h1000_0000;
        mp_key[1] = 32'h2000_0000;
        mp_key[2] = 32'h4000_0000;
        mp_key[3] = 32'h8000_0000;
        msk[0][1] = 32'h0000_FF00;
        sft[0][1] = 6'b111100;
        msk[3][1] = 32'hF000_0000;
        sft[3][1] = 6'd28;

        #1 reset_n = 1'b0;
        #1;
        chk("rst_vld", 72'(bus.pkt_vld_out), 72'd0);
        chk("rst_rdy", 72'(bus.evt_rdy_out), 72'd0);
        chk("rst_lvl", 72'(lvl), 72'd0);
        chk("rst_cnt", 72'(cnt), 72'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Field mapping, parity and first-packet latency
        bus.pkt_rdy_in = 1'b1;
        send(0, 32'h0000_1234, 32'h0, 72'h00000000_10012034_01);
        chk("latency_vld", 72'(bus.pkt_vld_out), 72'd1);
        chk("latency_lvl", 72'(lvl), 72'd1);
        drain("map");
        chk("cnt_after_first", 72'(cnt), 72'd1);

        // Payload mode
        pld_en[0] = 1'b1;
        send(0, 32'h0000_1234, 32'hFFFF_FFFF, 72'hFFFFFFFF_10012034_02);
        drain("payload");
        pld_en[0] = 1'b0;

        // Right shift field, payload ignored when disabled
        send(3, 32'h9000_0003, 32'h5555_5555, 72'h00000000_8000000B_01);
        drain("rshift");

        // Round-robin fairness with all channels holding valid
        cur_exp[0] = 72'h00000000_10000000_00;
        cur_exp[1] = 72'h00000000_20000001_01;
        cur_exp[2] = 72'h00000000_40000002_01;
        cur_exp[3] = 72'h00000000_80000003_00;
        for (int c = 0; c < NCH; c++) begin
            bus.evt_data_in[c] = 32'(c);
            bus.evt_vld_in[c]  = 1'b1;
        end
        acc_seq.delete();
        for (int n = 0; n < 8; n++) cycle();
        bus.evt_vld_in = '0;
        chk("rr_count", 72'(acc_seq.size()), 72'd8);
        for (int n = 0; n < 8 && n < acc_seq.size(); n++) begin
            chk($sformatf("rr_order_%0d", n), 72'(acc_seq[n]), 72'(rr_exp[n]));
        end
        drain("rr");
        chk("cnt_after_rr", 72'(cnt), 72'd11);

        // Back-pressure until full, then release
        bus.pkt_rdy_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(2, 32'(k), 32'h0, {32'h0, 32'h4000_0000 | 32'(k), htab[k-1]});
        end
        chk("full_lvl", 72'(lvl), 72'd4);
        bus.evt_data_in[2] = 32'd5;
        bus.evt_vld_in[2]  = 1'b1;
        cur_exp[2]         = {32'h0, 32'h4000_0005, htab[4]};
        accepted[2]        = 1'b0;
        cycle();
        chk("full_no_accept", 72'(accepted[2]), 72'd0);
        chk("full_lvl_hold", 72'(lvl), 72'd4);
        chk("full_rdy_low", 72'(bus.evt_rdy_out), 72'd0);
        bus.pkt_rdy_in = 1'b1;
        send(2, 32'd5, 32'h0, {32'h0, 32'h4000_0005, htab[4]});
        chk("release_cnt", 72'(cnt), 72'd13);
        chk("release_lvl", 72'(lvl), 72'd3);
        t0 = $time;
        for (int k = 6; k <= 10; k++) begin
            send(2, 32'(k), 32'h0, {32'h0, 32'h4000_0000 | 32'(k), htab[k-1]});
        end
        chk("stream_rate", 72'(($time - t0) / 10), 72'd5);
        chk("stream_cnt", 72'(cnt), 72'd18);
        chk("stream_lvl", 72'(lvl), 72'd3);
        drain("bp");
        chk("bp_cnt", 72'(cnt), 72'd21);

        // Simultaneous push/pop at level 2
        bus.pkt_rdy_in = 1'b0;
        pld_en[1]      = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            send(1, 32'(k), 32'h1, {32'h1, 32'h2000_0000 | 32'(k), htab[k-1] | 8'h02});
        end
        chk("pp_lvl_start", 72'(lvl), 72'd2);
        bus.pkt_rdy_in = 1'b1;
        for (int k = 3; k <= 6; k++) begin
            send(1, 32'(k), 32'h1, {32'h1, 32'h2000_0000 | 32'(k), htab[k-1] | 8'h02});
            chk($sformatf("pp_lvl_%0d", k), 72'(lvl), 72'd2);
        end
        drain("pushpop");
        pld_en[1] = 1'b0;
        chk("pp_cnt", 72'(cnt), 72'd27);

        // Reset with packets queued
        bus.pkt_rdy_in = 1'b0;
        send(0, 32'd0, 32'h0, 72'h00000000_10000000_00);
        send(1, 32'd1, 32'h0, 72'h00000000_20000001_01);
        send(2, 32'd2, 32'h0, 72'h00000000_40000002_01);
        chk("pre_reset_lvl", 72'(lvl), 72'd3);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_vld", 72'(bus.pkt_vld_out), 72'd0);
        chk("mid_rst_lvl", 72'(lvl), 72'd0);
        chk("mid_rst_cnt", 72'(cnt), 72'd0);
        chk("mid_rst_rdy", 72'(bus.evt_rdy_out), 72'd0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Counter wrap from a preloaded all-ones count
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        chk("preload_cnt", 72'(cnt), 72'hFFFF_FFFF);
        @(negedge clk);
        #1 bus.pkt_rdy_in = 1'b1;
        send(3, 32'd3, 32'h0, 72'h00000000_80000003_00);
        drain("wrap");
        chk("wrap_cnt", 72'(cnt), 72'd0);

        chk("sb_empty_end", 72'(sb.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
